// File: rtl/baccarat_datapath_if.sv
// Load strobes from the dealing FSM and the card/score values returned to it.
interface baccarat_datapath_if;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic [3:0] new_card;
  logic [3:0] pcard1_rank, pcard2_rank, pcard3_rank;
  logic [3:0] dcard1_rank, dcard2_rank, dcard3_rank;
  logic [3:0] pscore, dscore, pcard3;
  logic [2:0] cards_dealt;
  logic       deal_error;

  modport master (
    output load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3,
    input  new_card, pcard1_rank, pcard2_rank, pcard3_rank,
    input  dcard1_rank, dcard2_rank, dcard3_rank, pscore, dscore, pcard3,
    input  cards_dealt, deal_error
  );

  modport slave (
    input  load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3,
    output new_card, pcard1_rank, pcard2_rank, pcard3_rank,
    output dcard1_rank, dcard2_rank, dcard3_rank, pscore, dscore, pcard3,
    output cards_dealt, deal_error
  );
endinterface

// File: rtl/baccarat_datapath.sv
// Baccarat card datapath: free-running shoe counter, six card registers and
// combinational hand scores for the dealing FSM.
module baccarat_datapath #(
  parameter int unsigned START_RANK = 1
) (
  input logic                 slow_clock,
  input logic                 reset,
  baccarat_datapath_if.slave  dp
);

  localparam logic [3:0] StartRank = 4'(START_RANK);

  // Index 0..2 are player cards 1..3, 3..5 are dealer cards 1..3.
  logic [3:0] card_q [6];
  logic [3:0] new_card_q;
  logic [2:0] cards_dealt_q, cards_dealt_d;
  logic       deal_error_q;
  logic [5:0] load;
  logic [5:0] occupied;
  logic [3:0] num_loads;
  logic [3:0] dealt_sum;

  function automatic logic [3:0] card_value(input logic [3:0] rank);
    return (rank <= 4'd9) ? rank : 4'd0;
  endfunction

  // Sum is at most 27, so two compare/subtract steps cover mod 10.
  function automatic logic [3:0] mod10(input logic [4:0] s);
    logic [4:0] r;
    if (s >= 5'd20)      r = s - 5'd20;
    else if (s >= 5'd10) r = s - 5'd10;
    else                 r = s;
    return r[3:0];
  endfunction

  assign load = {dp.load_dcard3, dp.load_dcard2, dp.load_dcard1,
                 dp.load_pcard3, dp.load_pcard2, dp.load_pcard1};

  always_comb begin
    num_loads = 4'd0;
    occupied  = '0;
    for (int i = 0; i < 6; i++) begin
      num_loads   = num_loads + {3'd0, load[i]};
      occupied[i] = (card_q[i] != 4'd0);
    end
    dealt_sum     = {1'b0, cards_dealt_q} + num_loads;
    cards_dealt_d = (dealt_sum > 4'd6) ? 3'd6 : dealt_sum[2:0];
  end

  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      new_card_q    <= StartRank;
      cards_dealt_q <= 3'd0;
      deal_error_q  <= 1'b0;
      for (int i = 0; i < 6; i++) card_q[i] <= 4'd0;
    end else begin
      new_card_q    <= (new_card_q == 4'd13) ? 4'd1 : new_card_q + 4'd1;
      cards_dealt_q <= cards_dealt_d;
      if (|(load & occupied)) deal_error_q <= 1'b1;
      for (int i = 0; i < 6; i++) begin
        if (load[i]) card_q[i] <= new_card_q;
      end
    end
  end

  assign dp.new_card    = new_card_q;
  assign dp.pcard1_rank = card_q[0];
  assign dp.pcard2_rank = card_q[1];
  assign dp.pcard3_rank = card_q[2];
  assign dp.dcard1_rank = card_q[3];
  assign dp.dcard2_rank = card_q[4];
  assign dp.dcard3_rank = card_q[5];
  assign dp.pcard3      = card_value(card_q[2]);
  assign dp.pscore      = mod10(5'(card_value(card_q[0])) + 5'(card_value(card_q[1]))
                                + 5'(card_value(card_q[2])));
  assign dp.dscore      = mod10(5'(card_value(card_q[3])) + 5'(card_value(card_q[4]))
                                + 5'(card_value(card_q[5])));
  assign dp.cards_dealt = cards_dealt_q;
  assign dp.deal_error  = deal_error_q;

endmodule

// File: tb/tb_baccarat_datapath.sv
// Randomised and directed checks of baccarat_datapath against a card-game model.
module tb_baccarat_datapath;

  logic       clk;
  logic       reset;
  logic [5:0] ld;
  int         n_total;
  int         n_bad;

  // Reference model: shoe rank, six cards (p1,p2,p3,d1,d2,d3), deal count, error.
  int m_shoe;
  int m_card [6];
  int m_cnt;
  bit m_err;

  baccarat_datapath_if dp ();

  assign dp.load_pcard1 = ld[0];
  assign dp.load_pcard2 = ld[1];
  assign dp.load_pcard3 = ld[2];
  assign dp.load_dcard1 = ld[3];
  assign dp.load_dcard2 = ld[4];
  assign dp.load_dcard3 = ld[5];

  baccarat_datapath #(.START_RANK(1)) dut (
    .slow_clock (clk),
    .reset      (reset),
    .dp         (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int val(input int rank);
    return (rank >= 1 && rank <= 9) ? rank : 0;
  endfunction

  task automatic model_reset();
    m_shoe = 1;
    m_cnt  = 0;
    m_err  = 0;
    for (int i = 0; i < 6; i++) m_card[i] = 0;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ":new_card"}, dp.new_card, m_shoe);
    check_eq({tag, ":p1"}, dp.pcard1_rank, m_card[0]);
    check_eq({tag, ":p2"}, dp.pcard2_rank, m_card[1]);
    check_eq({tag, ":p3"}, dp.pcard3_rank, m_card[2]);
    check_eq({tag, ":d1"}, dp.dcard1_rank, m_card[3]);
    check_eq({tag, ":d2"}, dp.dcard2_rank, m_card[4]);
    check_eq({tag, ":d3"}, dp.dcard3_rank, m_card[5]);
    check_eq({tag, ":pscore"}, dp.pscore, (val(m_card[0]) + val(m_card[1]) + val(m_card[2])) % 10);
    check_eq({tag, ":dscore"}, dp.dscore, (val(m_card[3]) + val(m_card[4]) + val(m_card[5])) % 10);
    check_eq({tag, ":pcard3"}, dp.pcard3, val(m_card[2]));
    check_eq({tag, ":cards_dealt"}, dp.cards_dealt, m_cnt);
    check_eq({tag, ":deal_error"}, dp.deal_error, m_err);
  endtask

  // Applies strobes for one rising edge, then checks everything 1 time unit later.
  task automatic do_edge(input logic [5:0] loads, input string tag);
    int n;
    ld = loads;
    @(posedge clk);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (loads[i]) begin
        if (m_card[i] != 0) m_err = 1;
        m_card[i] = m_shoe;
        n++;
      end
    end
    m_cnt  = (m_cnt + n > 6) ? 6 : m_cnt + n;
    m_shoe = m_shoe % 13 + 1;
    #1;
    ld = '0;
    check_all(tag);
  endtask

  // Called just after an edge: reset takes effect at once, released well before the next edge.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    reset = 1'b0;
  endtask

  task automatic advance_to(input int rank);
    for (int k = 0; k < 13 && m_shoe != rank; k++) do_edge(6'b0, "idle");
    check_eq("advance_to", dp.new_card, rank);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    ld      = '0;
    reset   = 1'b1;
    model_reset();
    #1;
    check_all("por");
    #1;
    reset = 1'b0;

    // T1: reset in the middle of a deal.
    do_edge(6'b001001, "t1a");
    do_edge(6'b000010, "t1b");
    do_reset("t1_reset");

    // T2: p1,d1,p2,d2 on ranks 1..4.
    do_edge(6'b000001, "t2");
    do_edge(6'b001000, "t2");
    do_edge(6'b000010, "t2");
    do_edge(6'b010000, "t2");
    check_eq("t2_pscore", dp.pscore, 4);
    check_eq("t2_dscore", dp.dscore, 6);
    check_eq("t2_dealt", dp.cards_dealt, 4);
    check_eq("t2_err", dp.deal_error, 0);

    // T3: shoe wrap and a face-card capture.
    do_reset("t3_reset");
    for (int k = 0; k < 12; k++) do_edge(6'b0, "t3_idle");
    check_eq("t3_rank13", dp.new_card, 13);
    do_edge(6'b000001, "t3_cap");
    check_eq("t3_p1", dp.pcard1_rank, 13);
    check_eq("t3_pscore", dp.pscore, 0);
    check_eq("t3_wrap", dp.new_card, 1);

    // T4: 13+7 -> 7, then 9+8 -> 7.
    do_reset("t4_reset");
    advance_to(13);
    do_edge(6'b000001, "t4");
    advance_to(7);
    do_edge(6'b000010, "t4");
    check_eq("t4_pscore_a", dp.pscore, 7);
    do_reset("t4_reset2");
    advance_to(9);
    do_edge(6'b000001, "t4");
    advance_to(8);
    do_edge(6'b000010, "t4");
    check_eq("t4_pscore_b", dp.pscore, 7);

    // T5: both third cards on the same edge.
    do_reset("t5_reset");
    advance_to(9);
    do_edge(6'b100100, "t5");
    check_eq("t5_pcard3", dp.pcard3, 9);
    check_eq("t5_d3", dp.dcard3_rank, 9);
    check_eq("t5_dealt", dp.cards_dealt, 2);
    check_eq("t5_err", dp.deal_error, 0);

    // T6: overwrite sets a sticky error; deal count saturates.
    do_reset("t6_reset");
    do_edge(6'b000001, "t6");
    do_edge(6'b000001, "t6");
    check_eq("t6_err", dp.deal_error, 1);
    for (int k = 0; k < 100; k++) do_edge(6'b0, "t6_hold");
    do_reset("t6_clear");
    for (int k = 0; k < 8; k++) begin
      logic [5:0] one;
      one = 6'(1 << (k % 6));
      do_edge(one, "t6_sat");
    end
    check_eq("t6_dealt", dp.cards_dealt, 6);
    do_reset("t6_all");
    do_edge(6'b111111, "t6_all6");

    // Random traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      logic [5:0] r;
      if ($urandom_range(0, 39) == 0) do_reset("rnd_reset");
      case ($urandom_range(0, 3))
        0:       r = 6'($urandom_range(0, 63));
        1:       r = 6'(1 << $urandom_range(0, 5));
        default: r = '0;
      endcase
      do_edge(r, "rnd");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=0 expected=1");
    $fatal(1, "timeout");
  end

endmodule
